conv_tap_addr_gen: RTL and testbench
====================================

# conv_tap_addr_gen

Sequential address generator for the convolution datapath. From a run-time layer configuration, it walks every (output pixel, kernel tap) pair and emits the signed input-feature-map coordinate for each tap, one tap per cycle under valid/ready backpressure. It generalises the fixed-parameter input coordinate calculation to run-time stride, padding and dilation, 2-D iteration, and out-of-bounds (zero-pad) flagging. It feeds the input-buffer read port and the MAC array's accumulate/flush control.

## Interface
Parameters:
- ADDR_WIDTH, 16, unsigned width of every dimension and loop index.
- CFG_WIDTH, 4, width of the stride, padding and dilation config fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; latches the config and begins a run when idle.
- in_h, in_w  in  ADDR_WIDTH  input feature-map height and width.
- out_h, out_w  in  ADDR_WIDTH  output feature-map height and width.
- k_h, k_w  in  ADDR_WIDTH  kernel height and width.
- stride, padding, dilation  in  CFG_WIDTH each  unsigned; dilation 0 is treated as 1, stride 0 is treated as 1.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at the end of a run.
- out_valid  out  1  tap beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_row, out_col  out  ADDR_WIDTH+1  signed input coordinates.
- out_oy, out_ox, out_ky, out_kx  out  ADDR_WIDTH  loop indices of the beat.
- out_pad  out  1  coordinate is outside the input map; consumer substitutes zero.
- out_last_tap  out  1  last kernel tap of the current output pixel.
- out_last  out  1  final beat of the run.

## Operation
- Loop order, outermost to innermost: oy, ox, ky, kx. Each index runs from 0 to dim−1 and wraps to 0, carrying into the next-outer index.
- Coordinates: out_row = oy·stride + ky·dilation − padding; out_col = ox·stride + kx·dilation − padding.
- Coordinates are computed incrementally with no multipliers. Row/col base registers advance by stride on oy/ox steps. Tap offset registers advance by dilation on ky/kx steps and reset to 0 on wrap.
- Arithmetic is carried at ADDR_WIDTH+1 bits, signed. Configurations with oy·stride + ky·dilation ≥ 2^ADDR_WIDTH are illegal; behaviour is undefined and not checked.
- out_pad = (row < 0) | (row ≥ in_h) | (col < 0) | (col ≥ in_w). The comparisons are signed, with in_h and in_w zero-extended.
- out_last_tap = (ky == k_h−1) & (kx == k_w−1).
- out_last = out_last_tap & (oy == out_h−1) & (ox == out_w−1).
- FSM states:
  - IDLE: start → RUN, or start → FIN if any of out_h, out_w, k_h, k_w is 0.
  - RUN: the handshake on an out_last beat → FIN.
  - FIN: unconditional → IDLE; done is asserted while in FIN.
- start is ignored in RUN and FIN. Config inputs are sampled only on an accepted start; later changes have no effect on the run.

## Timing
- Reset (rst_n low at a clock edge): state IDLE; busy, done and out_valid are 0; every coordinate, index and flag output is 0. Reset applies in any state and abandons a run in progress with no done pulse.
- Start accepted at edge t: busy=1 and out_valid=1 from t+1, carrying the first beat (all indices 0).
- A beat is transferred on any edge where out_valid & out_ready. The next beat appears on the following cycle, giving a throughput of 1 tap/cycle.
- While out_valid & !out_ready, all beat outputs hold stable. out_valid never drops without a handshake.
- Final beat accepted at edge e: out_valid=0 and done=1 in cycle e+1; busy=0 from e+2. A new start is accepted from e+2.
- Zero-dimension start at t: done=1 in cycle t+1, no beats issued, busy high only in cycle t+1.
- Total beats per run = out_h·out_w·k_h·k_w.

## Structure
- Shared package conv_pkg holds:
  - the FSM state enum (IDLE, RUN, FIN);
  - the localparam COORD_WIDTH = ADDR_WIDTH+1;
  - the signed coordinate typedef.
- One sub-module, conv_tap_counter: a wrap counter with inc enable, a limit input, a wrap/last output, and an accumulator that steps by a configured amount and clears on wrap. It is instantiated four times (oy, ox, ky, kx). The top module holds the FSM, the row/col adders and the pad/last logic.

## Test plan
- Case: in 3×3, out 3×3, k 3×3, stride 1, pad 1, dil 1, out_ready=1. Required: 81 beats. Beat 0: row −1, col −1, pad 1. Beat 4: row 0, col 0, pad 0, oy=ox=ky=kx=1−1/1 pattern (oy 0, ox 0, ky 1, kx 1). Beat 80: row 3, col 3, pad 1, last 1. done 1 cycle after beat 80.
- Case: in 7×7, out 2×2, k 3×3, stride 2, pad 0, dil 2. Required: beat (oy 1, ox 1, ky 2, kx 2) gives row 6, col 6, pad 0; no beat has pad 1.
- Backpressure: toggle out_ready pseudo-randomly on the 3×3 case. Required: outputs stable while stalled; the same 81-beat sequence is produced; no beat is dropped or duplicated.
- Zero dimension: start with k_w=0. Required: done pulse at t+1, no out_valid.
- Start while busy: a second start pulse during RUN is ignored. Required: 81 beats and a single done.
- Mid-run reset: rst_n low for 1 cycle after beat 10. Required: all outputs 0 next cycle, no done; a fresh start reissues beat 0.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types for the convolution tap address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int COORD_WIDTH    = DEF_ADDR_WIDTH + 1;

   typedef logic signed [COORD_WIDTH-1:0] coord_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_tap_counter.sv
`default_nettype none
// ============================================================================
// Module      : conv_tap_counter
// Description : Wrapping loop index with a stepped accumulator cleared on wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_tap_counter #(
   parameter int ADDR_WIDTH = 16,
   parameter int ACC_WIDTH  = 17
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  inc,
   input  logic [ADDR_WIDTH-1:0] limit,
   input  logic [ACC_WIDTH-1:0]  step,
   output logic [ADDR_WIDTH-1:0] idx,
   output logic [ACC_WIDTH-1:0]  acc,
   output logic                  last,
   output logic                  wrap
);

   logic [ADDR_WIDTH-1:0] r_idx;
   logic [ACC_WIDTH-1:0]  r_acc;

   assign last = (r_idx == (limit - ADDR_WIDTH'(1)));
   // wrap doubles as the carry into the next-outer counter
   assign wrap = inc & last;
   assign idx  = r_idx;
   assign acc  = r_acc;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         r_idx <= '0;
         r_acc <= '0;
      end else if (inc) begin
         if (last) begin
            r_idx <= '0;
            r_acc <= '0;
         end else begin
            r_idx <= r_idx + ADDR_WIDTH'(1);
            r_acc <= r_acc + step;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_tap_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_tap_addr_gen
// Description : Walks every (output pixel, kernel tap) pair and emits the
//               signed input coordinate plus pad/last flags per beat.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_tap_addr_gen
   import conv_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int CFG_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] in_h,
   input  logic [ADDR_WIDTH-1:0] in_w,
   input  logic [ADDR_WIDTH-1:0] out_h,
   input  logic [ADDR_WIDTH-1:0] out_w,
   input  logic [ADDR_WIDTH-1:0] k_h,
   input  logic [ADDR_WIDTH-1:0] k_w,
   input  logic [CFG_WIDTH-1:0]  stride,
   input  logic [CFG_WIDTH-1:0]  padding,
   input  logic [CFG_WIDTH-1:0]  dilation,
   output logic                  busy,
   output logic                  done,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   out_row,
   output logic [ADDR_WIDTH:0]   out_col,
   output logic [ADDR_WIDTH-1:0] out_oy,
   output logic [ADDR_WIDTH-1:0] out_ox,
   output logic [ADDR_WIDTH-1:0] out_ky,
   output logic [ADDR_WIDTH-1:0] out_kx,
   output logic                  out_pad,
   output logic                  out_last_tap,
   output logic                  out_last
);

   localparam int C_COORD_W = ADDR_WIDTH + 1;

   state_t                r_state;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_valid;
   logic [ADDR_WIDTH-1:0] r_in_h;
   logic [ADDR_WIDTH-1:0] r_in_w;
   logic [ADDR_WIDTH-1:0] r_out_h;
   logic [ADDR_WIDTH-1:0] r_out_w;
   logic [ADDR_WIDTH-1:0] r_k_h;
   logic [ADDR_WIDTH-1:0] r_k_w;
   logic [CFG_WIDTH-1:0]  r_stride;
   logic [CFG_WIDTH-1:0]  r_padding;
   logic [CFG_WIDTH-1:0]  r_dilation;

   logic                  w_start_ok;
   logic                  w_zero;
   logic                  w_fire;
   logic [C_COORD_W-1:0]  w_stride_ext;
   logic [C_COORD_W-1:0]  w_dil_ext;
   logic [C_COORD_W-1:0]  w_pad_ext;

   logic [ADDR_WIDTH-1:0] w_oy_idx, w_ox_idx, w_ky_idx, w_kx_idx;
   logic [C_COORD_W-1:0]  w_oy_acc, w_ox_acc, w_ky_acc, w_kx_acc;
   logic                  w_oy_last, w_ox_last, w_ky_last, w_kx_last;
   logic                  w_oy_wrap, w_ox_wrap, w_ky_wrap, w_kx_wrap;

   logic signed [C_COORD_W-1:0] w_row;
   logic signed [C_COORD_W-1:0] w_col;
   logic                        w_pad;
   logic                        w_last_tap;
   logic                        w_last;

   assign w_start_ok   = (r_state == ST_IDLE) & start;
   assign w_zero       = (out_h == '0) | (out_w == '0) | (k_h == '0) | (k_w == '0);
   assign w_fire       = r_valid & out_ready;
   assign w_stride_ext = {{(C_COORD_W-CFG_WIDTH){1'b0}}, r_stride};
   assign w_dil_ext    = {{(C_COORD_W-CFG_WIDTH){1'b0}}, r_dilation};
   assign w_pad_ext    = {{(C_COORD_W-CFG_WIDTH){1'b0}}, r_padding};

   // Innermost kx steps on every transfer; each wrap carries outward.
   conv_tap_counter #(.ADDR_WIDTH(ADDR_WIDTH), .ACC_WIDTH(C_COORD_W)) u_kx (
      .clk(clk), .rst_n(rst_n), .clr(w_start_ok), .inc(w_fire),
      .limit(r_k_w), .step(w_dil_ext),
      .idx(w_kx_idx), .acc(w_kx_acc), .last(w_kx_last), .wrap(w_kx_wrap)
   );

   conv_tap_counter #(.ADDR_WIDTH(ADDR_WIDTH), .ACC_WIDTH(C_COORD_W)) u_ky (
      .clk(clk), .rst_n(rst_n), .clr(w_start_ok), .inc(w_kx_wrap),
      .limit(r_k_h), .step(w_dil_ext),
      .idx(w_ky_idx), .acc(w_ky_acc), .last(w_ky_last), .wrap(w_ky_wrap)
   );

   conv_tap_counter #(.ADDR_WIDTH(ADDR_WIDTH), .ACC_WIDTH(C_COORD_W)) u_ox (
      .clk(clk), .rst_n(rst_n), .clr(w_start_ok), .inc(w_ky_wrap),
      .limit(r_out_w), .step(w_stride_ext),
      .idx(w_ox_idx), .acc(w_ox_acc), .last(w_ox_last), .wrap(w_ox_wrap)
   );

   conv_tap_counter #(.ADDR_WIDTH(ADDR_WIDTH), .ACC_WIDTH(C_COORD_W)) u_oy (
      .clk(clk), .rst_n(rst_n), .clr(w_start_ok), .inc(w_ox_wrap),
      .limit(r_out_h), .step(w_stride_ext),
      .idx(w_oy_idx), .acc(w_oy_acc), .last(w_oy_last), .wrap(w_oy_wrap)
   );

   assign w_row = w_oy_acc + w_ky_acc - w_pad_ext;
   assign w_col = w_ox_acc + w_kx_acc - w_pad_ext;

   assign w_pad = (w_row < 0) | (w_row >= $signed({1'b0, r_in_h})) |
                  (w_col < 0) | (w_col >= $signed({1'b0, r_in_w}));
   assign w_last_tap = w_ky_last & w_kx_last;
   assign w_last     = w_last_tap & w_oy_last & w_ox_last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_valid    <= 1'b0;
         r_in_h     <= '0;
         r_in_w     <= '0;
         r_out_h    <= '0;
         r_out_w    <= '0;
         r_k_h      <= '0;
         r_k_w      <= '0;
         r_stride   <= '0;
         r_padding  <= '0;
         r_dilation <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_in_h     <= in_h;
                  r_in_w     <= in_w;
                  r_out_h    <= out_h;
                  r_out_w    <= out_w;
                  r_k_h      <= k_h;
                  r_k_w      <= k_w;
                  r_stride   <= (stride == '0) ? CFG_WIDTH'(1) : stride;
                  r_padding  <= padding;
                  r_dilation <= (dilation == '0) ? CFG_WIDTH'(1) : dilation;
                  r_busy     <= 1'b1;
                  if (w_zero) begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                     r_valid <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               // oy wrapping is exactly the handshake of the final beat
               if (w_oy_wrap) begin
                  r_state <= ST_FIN;
                  r_valid <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign out_valid    = r_valid;
   assign out_row      = r_valid ? w_row : '0;
   assign out_col      = r_valid ? w_col : '0;
   assign out_oy       = w_oy_idx;
   assign out_ox       = w_ox_idx;
   assign out_ky       = w_ky_idx;
   assign out_kx       = w_kx_idx;
   assign out_pad      = r_valid & w_pad;
   assign out_last_tap = r_valid & w_last_tap;
   assign out_last     = r_valid & w_last;

endmodule
`default_nettype wire

// File: tb/tb_conv_tap_addr_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_conv_tap_addr_gen
// Description : Scoreboard bench for conv_tap_addr_gen with directed runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_tap_addr_gen;
   import conv_pkg::*;

   localparam int AW  = 16;
   localparam int CFW = 4;

   typedef struct packed {
      coord_t        row;
      coord_t        col;
      logic [AW-1:0] oy;
      logic [AW-1:0] ox;
      logic [AW-1:0] ky;
      logic [AW-1:0] kx;
      logic          pad;
      logic          lt;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] in_h, in_w, out_h, out_w, k_h, k_w;
   logic [CFW-1:0] stride, padding, dilation;
   logic          busy, done, out_valid, out_ready;
   coord_t        out_row, out_col;
   logic [AW-1:0] out_oy, out_ox, out_ky, out_kx;
   logic          out_pad, out_last_tap, out_last;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    done_cnt = 0;
   bit    mon_en   = 1'b0;
   bit    rnd_mode = 1'b0;
   bit    stall    = 1'b0;
   bit    chk_done = 1'b0;
   bit    chk_busy = 1'b0;
   beat_t held;
   beat_t exp_q[$];
   beat_t cap[$];
   logic [15:0] lfsr = 16'hACE1;

   conv_tap_addr_gen #(.ADDR_WIDTH(AW), .CFG_WIDTH(CFW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_h(in_h), .in_w(in_w), .out_h(out_h), .out_w(out_w),
      .k_h(k_h), .k_w(k_w), .stride(stride), .padding(padding), .dilation(dilation),
      .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_col(out_col),
      .out_oy(out_oy), .out_ox(out_ox), .out_ky(out_ky), .out_kx(out_kx),
      .out_pad(out_pad), .out_last_tap(out_last_tap), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got row=%0d col=%0d oy=%0d ox=%0d ky=%0d kx=%0d pad=%0b lt=%0b last=%0b exp row=%0d col=%0d oy=%0d ox=%0d ky=%0d kx=%0d pad=%0b lt=%0b last=%0b",
                  name, act.row, act.col, act.oy, act.ox, act.ky, act.kx, act.pad, act.lt, act.last,
                  exp.row, exp.col, exp.oy, exp.ox, exp.ky, exp.kx, exp.pad, exp.lt, exp.last);
      end
   endtask

   function automatic beat_t cur_beat();
      beat_t b;
      b.row = out_row;  b.col = out_col;
      b.oy = out_oy;    b.ox = out_ox;   b.ky = out_ky;   b.kx = out_kx;
      b.pad = out_pad;  b.lt = out_last_tap;  b.last = out_last;
      return b;
   endfunction

   // Reference walk computed directly from the coordinate equations.
   task automatic push_run();
      int s, d, p, r, c;
      beat_t b;
      s = (stride == 0) ? 1 : int'(stride);
      d = (dilation == 0) ? 1 : int'(dilation);
      p = int'(padding);
      for (int oy = 0; oy < int'(out_h); oy++)
         for (int ox = 0; ox < int'(out_w); ox++)
            for (int ky = 0; ky < int'(k_h); ky++)
               for (int kx = 0; kx < int'(k_w); kx++) begin
                  r = oy * s + ky * d - p;
                  c = ox * s + kx * d - p;
                  b.row = coord_t'(r);  b.col = coord_t'(c);
                  b.oy = AW'(oy);  b.ox = AW'(ox);  b.ky = AW'(ky);  b.kx = AW'(kx);
                  b.pad  = (r < 0) || (r >= int'(in_h)) || (c < 0) || (c >= int'(in_w));
                  b.lt   = (ky == int'(k_h) - 1) && (kx == int'(k_w) - 1);
                  b.last = b.lt && (oy == int'(out_h) - 1) && (ox == int'(out_w) - 1);
                  exp_q.push_back(b);
               end
   endtask

   // Monitor: pops the scoreboard on every transfer and checks stall/done timing.
   always @(negedge clk) begin
      beat_t a, e;
      if (done) done_cnt++;
      if (!mon_en) begin
         stall = 1'b0;  chk_done = 1'b0;  chk_busy = 1'b0;
      end else begin
         a = cur_beat();
         if (chk_busy) begin
            chk("busy_after_fin", busy, 0);
            chk_busy = 1'b0;
         end
         if (chk_done) begin
            chk("done_after_last", {done, out_valid}, 2'b10);
            chk_done = 1'b0;
            chk_busy = 1'b1;
         end
         if (stall) begin
            chk("stall_valid", out_valid, 1);
            chk_beat("stall_hold", a, held);
         end
         stall = out_valid && !out_ready;
         held  = a;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk_beat("beat", a, e);
               cap.push_back(a);
               if (e.last) chk_done = 1'b1;
            end
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rnd_mode) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            out_ready = lfsr[0];
         end else out_ready = 1'b1;
      end
   end

   task automatic set_cfg(input int ih, iw, oh, ow, kh, kw, s, p, d);
      in_h = AW'(ih);  in_w = AW'(iw);  out_h = AW'(oh);  out_w = AW'(ow);
      k_h = AW'(kh);   k_w = AW'(kw);
      stride = CFW'(s);  padding = CFW'(p);  dilation = CFW'(d);
   endtask

   task automatic check_zero(input string name);
      chk({name, "_busy"},  busy, 0);
      chk({name, "_done"},  done, 0);
      chk({name, "_valid"}, out_valid, 0);
      chk({name, "_coord"}, {out_row, out_col}, 0);
      chk({name, "_idx"},   {out_oy, out_ox, out_ky, out_kx}, 0);
      chk({name, "_flags"}, {out_pad, out_last_tap, out_last}, 0);
   endtask

   task automatic begin_run();
      cap.delete();
      push_run();
      mon_en = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic finish_run(input string name, input int nbeats, input int d0);
      bit seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk({name, "_done_timeout"}, seen, 1);
      repeat (3) @(negedge clk);
      chk({name, "_queue_empty"}, exp_q.size(), 0);
      chk({name, "_beats"}, cap.size(), nbeats);
      chk({name, "_done_count"}, done_cnt - d0, 1);
   endtask

   initial begin
      int d0;
      bit hit;
      int npad;
      rst_n = 1'b0;  start = 1'b0;
      set_cfg(3, 3, 3, 3, 3, 3, 1, 1, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      // 3x3 same-padding walk
      d0 = done_cnt;
      begin_run();
      finish_run("c1", 81, d0);
      if (cap.size() == 81) begin
         chk("c1_b0_coord", {cap[0].row, cap[0].col, cap[0].pad}, {17'h1FFFF, 17'h1FFFF, 1'b1});
         chk("c1_b4_coord", {cap[4].row, cap[4].col, cap[4].pad}, 35'd0);
         chk("c1_b4_idx", {cap[4].oy, cap[4].ox, cap[4].ky, cap[4].kx}, {16'd0, 16'd0, 16'd1, 16'd1});
         chk("c1_b80", {cap[80].row, cap[80].col, cap[80].pad, cap[80].last}, {17'd3, 17'd3, 1'b1, 1'b1});
      end

      // stride 2, dilation 2, no padding
      set_cfg(7, 7, 2, 2, 3, 3, 2, 0, 2);
      d0 = done_cnt;
      begin_run();
      finish_run("c2", 36, d0);
      npad = 0;
      foreach (cap[i]) if (cap[i].pad) npad++;
      chk("c2_no_pad", npad, 0);
      if (cap.size() == 36) begin
         chk("c2_b35_idx", {cap[35].oy, cap[35].ox, cap[35].ky, cap[35].kx}, {16'd1, 16'd1, 16'd2, 16'd2});
         chk("c2_b35_coord", {cap[35].row, cap[35].col, cap[35].pad}, {17'd6, 17'd6, 1'b0});
      end

      // backpressure on the 3x3 case
      set_cfg(3, 3, 3, 3, 3, 3, 1, 1, 1);
      rnd_mode = 1'b1;
      d0 = done_cnt;
      begin_run();
      finish_run("bp", 81, d0);
      rnd_mode = 1'b0;

      // zero dimension
      set_cfg(3, 3, 3, 3, 3, 0, 1, 1, 1);
      d0 = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("zd_t1", {done, busy, out_valid}, 3'b110);
      @(negedge clk);
      chk("zd_t2", {done, busy, out_valid}, 3'b000);
      repeat (2) @(negedge clk);
      chk("zd_done_count", done_cnt - d0, 1);

      // second start during RUN with different config is ignored
      set_cfg(3, 3, 3, 3, 3, 3, 1, 1, 1);
      d0 = done_cnt;
      begin_run();
      repeat (5) @(posedge clk);
      #1 start = 1'b1;  out_h = 16'd5;  k_w = 16'd2;
      @(posedge clk); #1 start = 1'b0;
      finish_run("sb", 81, d0);

      // mid-run reset
      set_cfg(3, 3, 3, 3, 3, 3, 1, 1, 1);
      d0 = done_cnt;
      begin_run();
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (cap.size() >= 11) hit = 1'b1;
      end
      chk("mr_reach_beat10", hit, 1);
      @(posedge clk); #1 mon_en = 1'b0;  rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_zero("mr");
      repeat (3) @(negedge clk);
      chk("mr_no_done", done_cnt - d0, 0);
      exp_q.delete();
      d0 = done_cnt;
      begin_run();
      finish_run("mr_rerun", 81, d0);
      if (cap.size() > 0)
         chk("mr_rerun_b0", {cap[0].row, cap[0].oy, cap[0].ox, cap[0].ky, cap[0].kx},
             {17'h1FFFF, 64'd0});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
